// File: rtl/uart_tx_controller.sv
// UART transmitter: start, 8 data bits LSB first, even parity, stop.
// Each bit lasts OVERSAMPLE sample_ENABLE ticks. All outputs are driven from registers.
module uart_tx_controller #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_ENABLE,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic       Tx_DROP
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          parity;
  logic          accept;
  logic          bit_end;

  always_comb begin
    accept  = Tx_WR && Tx_EN && (state == IDLE);
    bit_end = sample_ENABLE && (tick_cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      parity   <= 1'b0;
      TxD      <= 1'b1;
      Tx_BUSY  <= 1'b0;
      Tx_DROP  <= 1'b0;
    end else begin
      Tx_DROP <= Tx_WR && !accept;
      // The tick counter runs only inside the frame; wrap is implicit at the power-of-two width.
      if (sample_ENABLE && (state != IDLE) && (state != SYNC)) begin
        tick_cnt <= tick_cnt + CW'(1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= Tx_DATA;
            parity  <= ^Tx_DATA;
            Tx_BUSY <= 1'b1;
            state   <= SYNC;
          end
        end
        SYNC: begin
          if (sample_ENABLE) begin
            state    <= START;
            TxD      <= 1'b0;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            TxD     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              TxD     <= parity;
              bit_idx <= '0;
              state   <= PARITY;
            end else begin
              TxD     <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            TxD   <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            Tx_BUSY <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          TxD     <= 1'b1;
          Tx_BUSY <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench for uart_tx_controller: frame shape, timing, rejected writes and reset abort.
// Expected frames are hand-written 11-bit words, bit i = i-th bit on the line.
module tb_uart_tx_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_ENABLE = 1'b0;
  logic       Tx_EN = 1'b0;
  logic       Tx_WR = 1'b0;
  logic [7:0] Tx_DATA = '0;
  logic       TxD;
  logic       Tx_BUSY;
  logic       Tx_DROP;

  int total = 0;
  int bad = 0;
  int se_div = 1;
  int se_cnt = 0;
  logic smp [0:4095];

  uart_tx_controller #(.OVERSAMPLE(16)) dut (
    .clk(clk),
    .reset(reset),
    .sample_ENABLE(sample_ENABLE),
    .Tx_EN(Tx_EN),
    .Tx_WR(Tx_WR),
    .Tx_DATA(Tx_DATA),
    .TxD(TxD),
    .Tx_BUSY(Tx_BUSY),
    .Tx_DROP(Tx_DROP)
  );

  initial forever #5 clk = ~clk;

  // Tick source: high every se_div-th cycle (se_div=1 ties it high).
  initial forever begin
    @(negedge clk);
    se_cnt++;
    sample_ENABLE = ((se_cnt % se_div) == 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue a write, record TxD every cycle while busy, then check the frame.
  // act_kind 1: write 0x55 at cycle act_cycle; 2: drop Tx_EN and write at act_cycle.
  task automatic run_frame(input string tag, input logic [7:0] data, input logic [10:0] exp,
                           input int bitlen, input int exp_busy, input int act_cycle,
                           input int act_kind, input int exp_drops);
    int k;
    int s;
    int drops;
    int i1;
    int i2;
    logic [10:0] first_w;
    logic [10:0] last_w;
    k = 0;
    s = -1;
    drops = 0;
    Tx_DATA = data;
    Tx_WR = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    check({tag, "_busy_on"}, 32'(Tx_BUSY), 32'd1);
    check({tag, "_drop_on_accept"}, 32'(Tx_DROP), 32'd0);
    while (Tx_BUSY && k < 4000) begin
      smp[k] = TxD;
      drops += int'(Tx_DROP);
      Tx_WR = 1'b0;
      if (k == act_cycle) begin
        if (act_kind == 1) begin
          Tx_DATA = 8'h55;
          Tx_WR = 1'b1;
        end else if (act_kind == 2) begin
          Tx_EN = 1'b0;
          Tx_WR = 1'b1;
        end
      end
      k++;
      @(negedge clk);
    end
    Tx_WR = 1'b0;
    drops += int'(Tx_DROP);
    check({tag, "_timeout"}, 32'(k < 4000), 32'd1);
    for (int i = 0; i < k; i++) begin
      if (smp[i] == 1'b0) begin
        s = i;
        break;
      end
    end
    check({tag, "_frame_len"}, 32'(k - s), 32'(11 * bitlen));
    if (exp_busy > 0) check({tag, "_busy_cycles"}, 32'(k), 32'(exp_busy));
    for (int i = 0; i < 11; i++) begin
      i1 = s + i * bitlen;
      i2 = s + (i + 1) * bitlen - 1;
      first_w[i] = (s >= 0 && i1 < k) ? smp[i1] : ~exp[i];
      last_w[i]  = (s >= 0 && i2 < k) ? smp[i2] : ~exp[i];
    end
    check({tag, "_bits_first"}, 32'(first_w), 32'(exp));
    check({tag, "_bits_last"}, 32'(last_w), 32'(exp));
    check({tag, "_drops"}, 32'(drops), 32'(exp_drops));
    check({tag, "_idle_txd"}, 32'(TxD), 32'd1);
  endtask

  initial begin
    Tx_EN = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(TxD), 32'd1);
    check("rst_busy", 32'(Tx_BUSY), 32'd0);
    check("rst_drop", 32'(Tx_DROP), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_se_txd", 32'(TxD), 32'd1);
    check("idle_se_busy", 32'(Tx_BUSY), 32'd0);

    run_frame("a5", 8'hA5, 11'h54A, 16, 177, -1, 0, 0);
    run_frame("b2b_07", 8'h07, 11'h60E, 16, 177, -1, 0, 0);
    run_frame("edge_wr", 8'h3C, 11'h478, 16, 177, 176, 1, 1);
    @(negedge clk);
    check("edge_wr_ignored_busy", 32'(Tx_BUSY), 32'd0);
    check("edge_wr_ignored_txd", 32'(TxD), 32'd1);
    run_frame("wr_busy", 8'hA5, 11'h54A, 16, 177, 40, 1, 1);

    Tx_EN = 1'b0;
    Tx_DATA = 8'h81;
    Tx_WR = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    check("en0_drop", 32'(Tx_DROP), 32'd1);
    check("en0_busy", 32'(Tx_BUSY), 32'd0);
    check("en0_txd", 32'(TxD), 32'd1);
    @(negedge clk);
    check("en0_drop_one_cycle", 32'(Tx_DROP), 32'd0);
    check("en0_busy2", 32'(Tx_BUSY), 32'd0);
    Tx_EN = 1'b1;
    @(negedge clk);

    run_frame("en_drop_mid", 8'h07, 11'h60E, 16, 177, 30, 2, 1);
    Tx_EN = 1'b1;
    @(negedge clk);

    se_div = 4;
    @(negedge clk);
    run_frame("div4_07", 8'h07, 11'h60E, 64, -1, -1, 0, 0);
    se_div = 1;
    @(negedge clk);

    Tx_DATA = 8'hA5;
    Tx_WR = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    repeat (69) @(negedge clk);
    check("pre_rst_d3", 32'(TxD), 32'd0);
    check("pre_rst_busy", 32'(Tx_BUSY), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_rst_txd", 32'(TxD), 32'd1);
    check("async_rst_busy", 32'(Tx_BUSY), 32'd0);
    repeat (3) @(negedge clk);
    check("held_rst_txd", 32'(TxD), 32'd1);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("no_resume_txd", 32'(TxD), 32'd1);
    check("no_resume_busy", 32'(Tx_BUSY), 32'd0);
    run_frame("post_rst_3c", 8'h3C, 11'h478, 16, 177, -1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
